// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogrammed controller's next-state engine.
package micro_pkg;

  localparam int USTATE_W = 4;
  localparam int OPCODE_W = 6;

  // Address-control field of a microinstruction.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DISP1 = 2'd1,
    DISP2 = 2'd2,
    SEQ   = 2'd3
  } addr_ctl_e;

  // Fixed microstate map. Values 11-15 are unused ROM words.
  typedef enum logic [USTATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMREAD = 4'd3,
    S_LW_WB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RDONE   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_TRAP    = 4'd10
  } ustate_e;

  // MIPS-style opcodes recognised by the dispatch tables.
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // Position of the 2-bit address-control field inside a 16-bit microinstruction.
  localparam int UI_W            = 16;
  localparam int UI_ADDR_CTL_LSB = 0;

  // Extracts the address-control field from a ROM word.
  function automatic logic [1:0] uinstr_addr_ctl(input logic [UI_W-1:0] uinstr);
    return uinstr[UI_ADDR_CTL_LSB +: 2];
  endfunction

endpackage

// File: rtl/micro_sequencer_dispatch_rom.sv
// Combinational dispatch tables: table 0 is used in decode, table 1 in memaddr.
// Unknown opcodes return TRAP_STATE with valid low.
module dispatch_rom
  import micro_pkg::*;
#(
  parameter int                 STATE_W    = 4,
  parameter int                 OP_W       = 6,
  parameter logic [STATE_W-1:0] TRAP_STATE = 4'd10
) (
  input  logic [OP_W-1:0]    opcode,
  input  logic               table_sel,
  output logic [STATE_W-1:0] target,
  output logic               valid
);

  // Table lookup with trap as the fall-through target.
  always_comb begin
    target = TRAP_STATE;
    valid  = 1'b0;
    if (!table_sel) begin
      case (opcode)
        OP_RTYPE: begin target = STATE_W'(S_REXEC);   valid = 1'b1; end
        OP_LW:    begin target = STATE_W'(S_MEMADDR); valid = 1'b1; end
        OP_SW:    begin target = STATE_W'(S_MEMADDR); valid = 1'b1; end
        OP_BEQ:   begin target = STATE_W'(S_BRANCH);  valid = 1'b1; end
        OP_J:     begin target = STATE_W'(S_JUMP);    valid = 1'b1; end
        default:  ;
      endcase
    end else begin
      case (opcode)
        OP_LW:   begin target = STATE_W'(S_MEMREAD); valid = 1'b1; end
        OP_SW:   begin target = STATE_W'(S_MEMWR);   valid = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-state engine: holds the microstate register that addresses the
// microcode ROM, selects the next microstate from addr_ctl/opcode, and
// reports instruction retirement and illegal-opcode traps.
//
// Stall semantics: while stall is high every register (state, instr_done,
// illegal_op, instr_count) holds its value; a pulse already on an output
// stays up for the stall and drops on the first unstalled edge.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int                 STATE_W    = 4,
  parameter int                 OP_W       = 6,
  parameter int                 CNT_W      = 16,
  parameter logic [STATE_W-1:0] TRAP_STATE = 4'd10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         addr_ctl,
  input  logic [OP_W-1:0]    opcode,
  input  logic               stall,
  output logic [STATE_W-1:0] state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] next_state;
  logic               done_q;
  logic               illegal_q;
  logic [CNT_W-1:0]   count_q;
  logic [STATE_W-1:0] disp_target;
  logic               disp_valid;
  logic               in_trap;
  logic               in_unused;
  logic               retire;

  // Only DISP2 reads the second table; every other mode ignores the result.
  dispatch_rom #(
    .STATE_W    (STATE_W),
    .OP_W       (OP_W),
    .TRAP_STATE (TRAP_STATE)
  ) u_dispatch_rom (
    .opcode    (opcode),
    .table_sel (addr_ctl == 2'(DISP2)),
    .target    (disp_target),
    .valid     (disp_valid)
  );

  assign in_trap   = (state_q == TRAP_STATE);
  assign in_unused = (state_q > STATE_W'(S_TRAP));

  // Next-state mux; trap and unused words always return to fetch.
  always_comb begin
    next_state = state_q;
    if (in_trap || in_unused) begin
      next_state = STATE_W'(S_FETCH);
    end else begin
      case (addr_ctl_e'(addr_ctl))
        FETCH:   next_state = STATE_W'(S_FETCH);
        DISP1:   next_state = disp_target;
        DISP2:   next_state = disp_target;
        SEQ:     next_state = state_q + STATE_W'(1);
        default: next_state = STATE_W'(S_FETCH);
      endcase
    end
  end

  // An instruction retires when a working microstate (1..9) returns to fetch.
  // Trap exits and unused-word recovery are not retirements.
  always_comb begin
    retire = 1'b0;
    if (state_q != STATE_W'(S_FETCH) && !in_trap && !in_unused &&
        next_state == STATE_W'(S_FETCH)) begin
      retire = 1'b1;
    end
  end

  // State, pulse and counter registers with stall hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STATE_W'(S_FETCH);
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else if (!stall) begin
      state_q   <= next_state;
      done_q    <= retire;
      illegal_q <= (next_state == TRAP_STATE);
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign state       = state_q;
  assign instr_done  = done_q;
  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

  // disp_valid is informational; trap routing already comes from disp_target.
  logic unused_ok;
  assign unused_ok = disp_valid;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Next-state engine for the microprogrammed multi-cycle controller. It drives the 4-bit `state` address into the microcode ROM.
- Each cycle it takes back the 2-bit address-control field of the current microinstruction and the instruction opcode, then selects the next microstate.
- Selection is one of four modes: fetch, sequential, dispatch table 1 or dispatch table 2.
- It also supports a memory stall, an illegal-opcode trap, and an instruction-retire pulse and counter.

Parameters:
- STATE_W, 4, microstate address width (16 ROM words).
- OP_W, 6, opcode width (MIPS-style).
- CNT_W, 16, retired-instruction counter width.
- TRAP_STATE, 4'd10, microstate entered on an illegal opcode.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- addr_ctl  input  2  address-control field of the current microinstruction.
- opcode  input  OP_W  opcode field of the instruction register.
- stall  input  1  memory not ready; freezes the sequencer.
- state  output  STATE_W  current microstate; addresses the microcode ROM.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- illegal_op  output  1  one-cycle pulse while in TRAP_STATE.
- instr_count  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (synchronous, `reset`=1 at an edge):
  - state=0, instr_done=0, illegal_op=0, instr_count=0.
  - reset overrides stall and all other inputs.
- `state` is a register. The ROM output is combinational from `state`, and next_state is combinational from addr_ctl/opcode, so there is 1 cycle per microstep.
- addr_ctl encoding:
  - 0 FETCH: next=0.
  - 1 DISP1: next=dispatch1[opcode].
  - 2 DISP2: next=dispatch2[opcode].
  - 3 SEQ: next=state+1, wrapping 15->0 modulo 2^STATE_W.
- dispatch1 (used in decode state 1):
  - R-type 000000 -> 6
  - lw 100011 -> 2
  - sw 101011 -> 2
  - beq 000100 -> 8
  - j 000010 -> 9
  - any other -> TRAP_STATE
- dispatch2 (used in memory-address state 2):
  - lw -> 3
  - sw -> 5
  - any other -> TRAP_STATE
- Microstate map (fixed):
  - 0 fetch
  - 1 decode
  - 2 memaddr
  - 3 memread
  - 4 lw writeback
  - 5 memwrite
  - 6 R exec
  - 7 R complete
  - 8 branch
  - 9 jump
  - 10 trap
  - 11-15 unused
- TRAP_STATE: the sequencer forces next=0 regardless of addr_ctl. This is a one-cycle trap state.
- Unused states 11-15: also force next=0.
- stall=1: state, instr_done, illegal_op and instr_count all hold. Any pending pulse is held, not repeated or dropped.
- instr_done:
  - Registered. Pulses 1 for exactly one cycle in the cycle after state transitions from a non-zero state, other than TRAP_STATE, to 0.
  - It does not pulse on reset, after a trap exit, or on a 15->0 SEQ wrap.
- instr_count:
  - Increments by 1 on the same edge that sets instr_done.
  - Wraps modulo 2^CNT_W with no saturation.
- illegal_op = registered flag, 1 exactly while state==TRAP_STATE (and not stalled out).
- Simultaneous events:
  - reset beats stall.
  - stall beats addr_ctl.
  - trap-forced next beats addr_ctl.
- Reset mid-instruction: the next cycle has state=0 and the count is cleared. No retire is reported.

Decomposition:
- Shared package `micro_pkg` holds:
  - addr_ctl enum: FETCH, DISP1, DISP2, SEQ.
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J.
  - microstate constants: S_FETCH … S_JUMP, S_TRAP.
  - the bit position of the addr_ctl field inside the 16-bit microinstruction, used by the top-level wiring.
- One sub-module, `dispatch_rom`: purely combinational. Inputs are opcode and table select; outputs are the target state plus a valid bit. It contains both dispatch tables.
- The sequencer core holds the state register, the next-state mux, the stall hold and the retire/trap logic.

Test Plan:
- Reset then lw: apply reset; opcode=100011 with addr_ctl sequence SEQ, DISP1, DISP2, SEQ, FETCH. Required: state goes 0,1,2,3,4,0. instr_done pulses once. instr_count=1.
- R-type then beq: opcode=000000 gives state 0,1,6,7,0. Then opcode=000100 gives 0,1,8,0. Required: instr_count=2 and exactly two instr_done pulses.
- Illegal opcode: opcode=111111 with DISP1 at state 1. Required: state=10 and illegal_op=1 for one cycle, then state=0. instr_done stays 0 and the count is unchanged.
- Stall: assert stall for 3 cycles at state 3 (lw). Required: state stays 3 for all 3 cycles and is 4 on the first unstalled edge. A stall held over the retire cycle delays the instr_done pulse without duplicating it.
- SEQ wrap and unused states: force SEQ from state 9 through to 15. Required: 15->0 with no instr_done. Also, any entry into state 11 is followed by state 0 on the next cycle.
- Counter wrap and mid-op reset: with CNT_W=4, retire 16 instructions and require instr_count=0. Then assert reset at state 6 and require state=0 and count=0 on the next cycle.
